pixel_writer: RTL
=================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: pt_valid  input  1  draw-point request valid.
REQ-004 SHALL have: pt_ready  output  1  point accepted on a cycle where pt_valid && pt_ready.
REQ-005 SHALL have: pt_x  input  10  pixel column, 0..639.
REQ-006 SHALL have: pt_y  input  9  pixel row, 0..479.
REQ-007 SHALL have: pt_erase  input  1  clear the pixel instead of setting it (see Configuration).
REQ-008 SHALL have: hcounter  input  11, and vcounter  input  10  VGA timing counters.
REQ-009 SHALL have: ready  input  1  SRAM controller idle and able to take a strobe.
REQ-010 SHALL have: address  output  18  SRAM word address.
REQ-011 SHALL have: data_read  input  16, and data_write  output  16  SRAM data.
REQ-012 SHALL have: read  output  1, and write  output  1  single-cycle SRAM strobes.
REQ-013 SHALL have: busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty; dropped  output  1  one-cycle pulse on an out-of-range point.

Function
REQ-014 SHALL buffer accepted points in a 4-entry FIFO; pt_ready = !full; no push when full, even if a pop occurs in the same cycle.
REQ-015 SHALL accept out-of-range points (pt_x>=640 or pt_y>=480) without storing them, pulsing dropped the next cycle.
REQ-016 SHALL compute address = pt_y*80 + pt_x[9:3] (18-bit, no overflow for legal input) and bit index = pt_x[2:0].
REQ-017 SHALL start an operation only in blanking (hcounter>=640 or vcounter>=480), FIFO non-empty, ready high, FSM in IDLE; a started operation completes regardless of the window.
REQ-018 SHALL use states IDLE -> ADDR -> RD_STROBE -> CAPTURE -> WR_STROBE -> WR_WAIT -> IDLE.
REQ-019 IDLE: read=0, write=0; on start, pop FIFO, go to ADDR.
REQ-020 ADDR: register address; go to RD_STROBE.
REQ-021 RD_STROBE: read=1 for exactly this cycle; go to CAPTURE.
REQ-022 CAPTURE: read=0; new_byte = data_read[7:0] with bit index set (or cleared on erase); go to WR_STROBE.
REQ-023 WR_STROBE: write=1 for exactly this cycle; data_write = {8'h00, new_byte}; address unchanged; go to WR_WAIT.
REQ-024 WR_WAIT: write=0; return to IDLE on the first cycle ready is high.
REQ-025 Latency SHALL be: pop at cycle n, address valid n+1, read=1 at n+2, write=1 at n+4.
REQ-026 Upper byte SHALL always be written as zero; data_read[15:8] is ignored (bit 13 is unreliable).
REQ-027 Duplicate points SHALL each perform a full read-modify-write; results are idempotent.

Reset
REQ-028 On reset the FSM SHALL go to IDLE, FIFO to empty, and read, write, dropped, busy to 0, with address=0 and data_write=0, on the next edge.
REQ-029 A reset asserted mid-operation SHALL abort it without a write strobe; the partially read word is left unchanged.

Configuration
REQ-030 Macro PIXEL_WRITER_ERASE_EN SHALL gate erase: defined -> pt_erase is stored per FIFO entry and clears the bit; undefined -> pt_erase is ignored and every point sets its bit.

Verification
REQ-031 Point (13,2) in vblank, data_read=16'h0000 -> read pulse at address 161, then write pulse with data_write=16'h0020.
REQ-032 Point (0,0) pushed at hcounter=100, vcounter=10 -> no strobe until hcounter=640, then read at address 0.
REQ-033 Five points pushed back-to-back while outside blanking -> pt_ready low after the 4th; the 5th is accepted only after the first pop.
REQ-034 Point (640,5) -> dropped pulse, no SRAM access, FIFO count unchanged.
REQ-035 With ERASE_EN, point (7,0, erase=1) and data_read=16'hFF80 -> data_write=16'h0000; without ERASE_EN -> data_write=16'h0080.
REQ-036 Reset asserted in CAPTURE -> no write pulse, FSM IDLE, busy=0 next cycle.

Source files
------------

// File: rtl/pixel_writer.sv
// pixel_writer: buffers draw-point requests in a 4-deep FIFO and performs one SRAM
// read-modify-write per point during video blanking. Optional erase: PIXEL_WRITER_ERASE_EN.
module pixel_writer (
   input  logic        clk,
   input  logic        reset,
   input  logic        pt_valid,
   output logic        pt_ready,
   input  logic [9:0]  pt_x,
   input  logic [8:0]  pt_y,
   input  logic        pt_erase,
   input  logic [10:0] hcounter,
   input  logic [9:0]  vcounter,
   input  logic        ready,
   output logic [17:0] address,
   input  logic [15:0] data_read,
   output logic [15:0] data_write,
   output logic        read,
   output logic        write,
   output logic        busy,
   output logic        dropped
);
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      RD_STROBE = 3'd2,
      CAPTURE   = 3'd3,
      WR_STROBE = 3'd4,
      WR_WAIT   = 3'd5
   } state_t;

   state_t      state_r, state_nxt_s;
   logic [9:0]  fifo_x_r [4];
   logic [8:0]  fifo_y_r [4];
   logic [1:0]  wr_ptr_r, rd_ptr_r;
   logic [2:0]  count_r, count_nxt_s;
   logic [2:0]  bit_idx_r;
   logic        erase_op_r;
   logic [17:0] address_r;
   logic [15:0] data_write_r;
   logic        read_r, write_r, busy_r, dropped_r;
   logic        in_range_s, accept_s, push_s, pop_s, blank_s, head_erase_s;
   logic [9:0]  head_x_s;
   logic [8:0]  head_y_s;
   logic [17:0] head_addr_s;
   logic [7:0]  mask_s, new_byte_s;
   logic        unused_s;

   // Byte address = y*80 + x/8, with y*80 built as y*64 + y*16.
   function automatic logic [17:0] pixel_addr(input logic [9:0] x, input logic [8:0] y);
      pixel_addr = {3'b000, y, 6'b000000} + {5'b00000, y, 4'b0000} + {11'b000_0000_0000, x[9:3]};
   endfunction

`ifdef PIXEL_WRITER_ERASE_EN
   logic fifo_e_r [4];

   // Erase flag travels with its point through the FIFO.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_e_r[wr_ptr_r] <= pt_erase;
      end
   end

   assign head_erase_s = fifo_e_r[rd_ptr_r];
   assign unused_s     = ^data_read[15:8];
`else
   assign head_erase_s = 1'b0;
   assign unused_s     = ^{pt_erase, data_read[15:8]};
`endif

   assign pt_ready    = (count_r != 3'd4);
   assign in_range_s  = (pt_x < 10'd640) && (pt_y < 9'd480);
   assign accept_s    = pt_valid && pt_ready;
   assign push_s      = accept_s && in_range_s;
   assign blank_s     = (hcounter >= 11'd640) || (vcounter >= 10'd480);
   assign pop_s       = (state_r == IDLE) && (count_r != 3'd0) && blank_s && ready;
   assign head_x_s    = fifo_x_r[rd_ptr_r];
   assign head_y_s    = fifo_y_r[rd_ptr_r];
   assign head_addr_s = pixel_addr(head_x_s, head_y_s);

   assign address    = address_r;
   assign data_write = data_write_r;
   assign read       = read_r;
   assign write      = write_r;
   assign busy       = busy_r;
   assign dropped    = dropped_r;

   // FIFO storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_x_r[wr_ptr_r] <= pt_x;
         fifo_y_r[wr_ptr_r] <= pt_y;
      end
   end

   // Occupancy after this cycle's push and pop.
   always_comb begin
      count_nxt_s = count_r;
      if (push_s && !pop_s) begin
         count_nxt_s = count_r + 3'd1;
      end else if (pop_s && !push_s) begin
         count_nxt_s = count_r - 3'd1;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Read-modify-write sequencer; once started it runs to completion.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (pop_s) state_nxt_s = ADDR;
            else       state_nxt_s = IDLE;
         end
         ADDR:      state_nxt_s = RD_STROBE;
         RD_STROBE: state_nxt_s = CAPTURE;
         CAPTURE:   state_nxt_s = WR_STROBE;
         WR_STROBE: state_nxt_s = WR_WAIT;
         WR_WAIT: begin
            if (ready) state_nxt_s = IDLE;
            else       state_nxt_s = WR_WAIT;
         end
         default:   state_nxt_s = IDLE;
      endcase
   end

   // Only the low byte carries pixels; the upper read byte is never trusted.
   always_comb begin
      mask_s = 8'd1 << bit_idx_r;
      if (erase_op_r) begin
         new_byte_s = data_read[7:0] & ~mask_s;
      end else begin
         new_byte_s = data_read[7:0] | mask_s;
      end
   end

   // State, FIFO bookkeeping and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         wr_ptr_r     <= 2'd0;
         rd_ptr_r     <= 2'd0;
         count_r      <= 3'd0;
         bit_idx_r    <= 3'd0;
         erase_op_r   <= 1'b0;
         address_r    <= 18'd0;
         data_write_r <= 16'h0000;
         read_r       <= 1'b0;
         write_r      <= 1'b0;
         busy_r       <= 1'b0;
         dropped_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         count_r <= count_nxt_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + 2'd1;
         end
         if (pop_s) begin
            rd_ptr_r   <= rd_ptr_r + 2'd1;
            address_r  <= head_addr_s;
            bit_idx_r  <= head_x_s[2:0];
            erase_op_r <= head_erase_s;
         end
         if (state_r == CAPTURE) begin
            data_write_r <= {8'h00, new_byte_s};
         end
         read_r    <= (state_nxt_s == RD_STROBE);
         write_r   <= (state_nxt_s == WR_STROBE);
         busy_r    <= (state_nxt_s != IDLE) || (count_nxt_s != 3'd0);
         dropped_r <= accept_s && !in_range_s;
      end
   end
endmodule
